updi_if: RTL and testbench

Byte-level UPDI transaction engine between a command source and the UART byte FIFOs of a UPDI programmer. It accepts an instruction, encodes the UPDI opcode, and streams SYNCH, opcode and payload bytes into the UART TX FIFO. Where the command requests it, it checks ACK bytes from the UART RX FIFO. A separate receive command moves a given number of response bytes from the UART RX FIFO into an output FIFO.

---
 rtl/updi_pkg.sv | 28 ++
 rtl/updi_if_if.sv | 53 +++++
 rtl/updi_opcode_encode.sv | 31 +++
 rtl/updi_if.sv | 143 ++++++++++++++
 tb/tb_updi_if.sv | 271 +++++++++++++++++++++++++++
 5 files changed

// File: rtl/updi_pkg.sv
// Shared types and constants for the UPDI byte-level transaction engine.
// Optional ACK checking is enabled by defining UPDI_ACK_CHECK_EN.
package updi_pkg;

  localparam int MAX_DATA_SIZE  = 64;
  localparam int DATA_ADDR_BITS = $clog2(MAX_DATA_SIZE);

  typedef enum logic [2:0] {
    LDS, STS, LD, ST, LDCS, STCS, REPEAT, KEY
  } updi_instruction;

  typedef enum logic [2:0] {
    S_IDLE, S_TX_SYNCH, S_TX_OPCODE, S_TX_DATA, S_WAIT_ACK, S_RX_DATA
  } updi_state_e;

  localparam logic [7:0] UPDI_SYNCH = 8'h55;
  localparam logic [7:0] UPDI_ACK   = 8'h40;

  localparam logic [7:0] OPC_LDS    = 8'h00;
  localparam logic [7:0] OPC_STS    = 8'h40;
  localparam logic [7:0] OPC_LD     = 8'h20;
  localparam logic [7:0] OPC_ST     = 8'h60;
  localparam logic [7:0] OPC_LDCS   = 8'h80;
  localparam logic [7:0] OPC_STCS   = 8'hC0;
  localparam logic [7:0] OPC_REPEAT = 8'hA0;
  localparam logic [7:0] OPC_KEY    = 8'hE0;

endpackage

// File: rtl/updi_if_if.sv
// Command and FIFO bus of the UPDI engine; slave is the engine's view,
// master is the command source / FIFO side.
interface updi_if_if;
  import updi_pkg::*;

  updi_instruction                   instruction;
  logic [1:0]                        size_a;
  logic [1:0]                        size_b;
  logic [1:0]                        ptr;
  logic [1:0]                        size_c;
  logic [3:0]                        cs_addr;
  logic                              sib;
  logic [MAX_DATA_SIZE-1:0][7:0]     data;
  logic [DATA_ADDR_BITS-1:0]         data_len;
  logic [MAX_DATA_SIZE-1:0]          wait_ack_after;
  logic                              tx_start;
  logic                              tx_ready;
  logic [DATA_ADDR_BITS-1:0]         rx_n_bytes;
  logic                              rx_start;
  logic                              rx_ready;
  logic                              ack_error;

  logic [7:0]                        out_rx_fifo_data;
  logic                              out_rx_fifo_wr_en;
  logic                              out_rx_fifo_full;
  logic [7:0]                        uart_rx_fifo_data;
  logic                              uart_rx_fifo_rd_en;
  logic                              uart_rx_fifo_empty;
  logic [7:0]                        uart_tx_fifo_data;
  logic                              uart_tx_fifo_wr_en;
  logic                              uart_tx_fifo_full;

  modport slave (
    input  instruction, size_a, size_b, ptr, size_c, cs_addr, sib,
           data, data_len, wait_ack_after, tx_start, rx_n_bytes, rx_start,
           out_rx_fifo_full, uart_rx_fifo_data, uart_rx_fifo_empty,
           uart_tx_fifo_full,
    output tx_ready, rx_ready, ack_error,
           out_rx_fifo_data, out_rx_fifo_wr_en, uart_rx_fifo_rd_en,
           uart_tx_fifo_data, uart_tx_fifo_wr_en
  );

  modport master (
    output instruction, size_a, size_b, ptr, size_c, cs_addr, sib,
           data, data_len, wait_ack_after, tx_start, rx_n_bytes, rx_start,
           out_rx_fifo_full, uart_rx_fifo_data, uart_rx_fifo_empty,
           uart_tx_fifo_full,
    input  tx_ready, rx_ready, ack_error,
           out_rx_fifo_data, out_rx_fifo_wr_en, uart_rx_fifo_rd_en,
           uart_tx_fifo_data, uart_tx_fifo_wr_en
  );

endinterface

// File: rtl/updi_opcode_encode.sv
// Combinational UPDI opcode encoder: instruction plus fields to opcode byte.
module updi_opcode_encode
  import updi_pkg::*;
(
  input  updi_instruction i_instruction,
  input  logic [1:0]      i_size_a,
  input  logic [1:0]      i_size_b,
  input  logic [1:0]      i_ptr,
  input  logic [1:0]      i_size_c,
  input  logic [3:0]      i_cs_addr,
  input  logic            i_sib,
  output logic [7:0]      o_opcode
);

  always_comb begin
    // NOTE: default assignment first so no path leaves o_opcode unassigned (no latch).
    o_opcode = OPC_LDS;
    case (i_instruction)
      LDS:     o_opcode = OPC_LDS    | {4'b0000, i_size_a, i_size_b};
      STS:     o_opcode = OPC_STS    | {4'b0000, i_size_a, i_size_b};
      LD:      o_opcode = OPC_LD     | {4'b0000, i_ptr, i_size_b};
      ST:      o_opcode = OPC_ST     | {4'b0000, i_ptr, i_size_b};
      LDCS:    o_opcode = OPC_LDCS   | {4'b0000, i_cs_addr};
      STCS:    o_opcode = OPC_STCS   | {4'b0000, i_cs_addr};
      REPEAT:  o_opcode = OPC_REPEAT | {6'b000000, i_size_b};
      KEY:     o_opcode = OPC_KEY    | {5'b00000, i_sib, i_size_c};
      default: o_opcode = OPC_LDS;
    endcase
  end

endmodule

// File: rtl/updi_if.sv
// UPDI transaction engine: streams SYNCH/opcode/payload to the UART TX FIFO,
// checks ACKs (UPDI_ACK_CHECK_EN) and moves response bytes to the output FIFO.
module updi_if
  import updi_pkg::*;
(
  input logic      clk,
  input logic      rst_n,
  updi_if_if.slave bus
);

  localparam logic [DATA_ADDR_BITS-1:0] ONE = DATA_ADDR_BITS'(1);

  updi_state_e                   r_state;
  logic [7:0]                    r_opcode;
  logic [MAX_DATA_SIZE-1:0][7:0] r_data;
  logic [MAX_DATA_SIZE-1:0]      r_wait_ack;
  logic [DATA_ADDR_BITS-1:0]     r_len;
  logic [DATA_ADDR_BITS-1:0]     r_idx;
  logic [DATA_ADDR_BITS-1:0]     r_rx_cnt;
  logic                          r_ack_error;

  logic [7:0] w_opcode;
  logic       w_tx_fire;
  logic       w_ack_fire;
  logic       w_rx_fire;
  logic       w_last_byte;
  logic       w_ack_bad;
  logic       w_tx_accept;

  updi_opcode_encode u_encode (
    .i_instruction (bus.instruction),
    .i_size_a      (bus.size_a),
    .i_size_b      (bus.size_b),
    .i_ptr         (bus.ptr),
    .i_size_c      (bus.size_c),
    .i_cs_addr     (bus.cs_addr),
    .i_sib         (bus.sib),
    .o_opcode      (w_opcode)
  );

  // FIFO strobes are decoded from the current state so they can honour full/empty in the same cycle.
  assign w_tx_fire   = !bus.uart_tx_fifo_full &&
                       (r_state inside {S_TX_SYNCH, S_TX_OPCODE, S_TX_DATA});
  assign w_ack_fire  = (r_state == S_WAIT_ACK) && !bus.uart_rx_fifo_empty;
  assign w_rx_fire   = (r_state == S_RX_DATA) && (r_rx_cnt != '0) &&
                       !bus.uart_rx_fifo_empty && !bus.out_rx_fifo_full;
  assign w_last_byte = (r_idx == r_len - ONE);
  assign w_tx_accept = (r_state == S_IDLE) && bus.tx_start;

`ifdef UPDI_ACK_CHECK_EN
  assign w_ack_bad = (bus.uart_rx_fifo_data != UPDI_ACK);
`else
  assign w_ack_bad = 1'b0;
`endif

  always_comb begin
    bus.uart_tx_fifo_data = UPDI_SYNCH;
    case (r_state)
      S_TX_OPCODE: bus.uart_tx_fifo_data = r_opcode;
      S_TX_DATA:   bus.uart_tx_fifo_data = r_data[r_idx];
      default:     bus.uart_tx_fifo_data = UPDI_SYNCH;
    endcase
  end

  assign bus.uart_tx_fifo_wr_en = w_tx_fire;
  assign bus.uart_rx_fifo_rd_en = w_ack_fire | w_rx_fire;
  assign bus.out_rx_fifo_wr_en  = w_rx_fire;
  assign bus.out_rx_fifo_data   = bus.uart_rx_fifo_data;
  assign bus.tx_ready           = (r_state == S_IDLE);
  assign bus.rx_ready           = (r_state == S_IDLE);
  assign bus.ack_error          = r_ack_error;

  // NOTE: payload registers carry no reset; they are always loaded at tx_start before being read.
  always_ff @(posedge clk) begin
    if (w_tx_accept) begin
      r_data     <= bus.data;
      r_wait_ack <= bus.wait_ack_after;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    // NOTE: non-blocking assignments so every register samples pre-edge values.
    if (!rst_n) begin
      r_state     <= S_IDLE;
      r_opcode    <= '0;
      r_len       <= '0;
      r_idx       <= '0;
      r_rx_cnt    <= '0;
      r_ack_error <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (bus.tx_start) begin
            r_opcode    <= w_opcode;
            r_len       <= bus.data_len;
            r_idx       <= '0;
            r_ack_error <= 1'b0;
            r_state     <= S_TX_SYNCH;
          end else if (bus.rx_start) begin
            r_rx_cnt <= bus.rx_n_bytes;
            r_state  <= S_RX_DATA;
          end
        end
        S_TX_SYNCH: begin
          if (w_tx_fire) r_state <= S_TX_OPCODE;
        end
        S_TX_OPCODE: begin
          if (w_tx_fire) r_state <= (r_len == '0) ? S_IDLE : S_TX_DATA;
        end
        S_TX_DATA: begin
          if (w_tx_fire) begin
            if (r_wait_ack[r_idx]) r_state <= S_WAIT_ACK;
            else if (w_last_byte)  r_state <= S_IDLE;
            else                   r_idx   <= r_idx + ONE;
          end
        end
        S_WAIT_ACK: begin
          if (w_ack_fire) begin
            if (w_ack_bad) begin
              r_ack_error <= 1'b1;
              r_state     <= S_IDLE;
            end else if (w_last_byte) begin
              r_state <= S_IDLE;
            end else begin
              r_idx   <= r_idx + ONE;
              r_state <= S_TX_DATA;
            end
          end
        end
        S_RX_DATA: begin
          if (r_rx_cnt == '0) begin
            r_state <= S_IDLE;
          end else if (w_rx_fire) begin
            r_rx_cnt <= r_rx_cnt - ONE;
            if (r_rx_cnt == ONE) r_state <= S_IDLE;
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_updi_if.sv
// Directed self-checking bench for updi_if with small TX/RX/output FIFO models.
module tb_updi_if;
  import updi_pkg::*;

`ifdef UPDI_ACK_CHECK_EN
  localparam logic EXP_BAD_ACK = 1'b1;
`else
  localparam logic EXP_BAD_ACK = 1'b0;
`endif

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  updi_if_if bus();

  updi_if dut (.clk(clk), .rst_n(rst_n), .bus(bus));

  int n_checks = 0;
  int n_pass   = 0;

  logic [7:0] tx_mem  [0:255];
  logic [7:0] out_mem [0:255];
  logic [7:0] rx_mem  [0:15];
  int tx_cnt  = 0;
  int out_cnt = 0;
  int rx_wr   = 0;
  int rx_rd   = 0;

  assign bus.uart_rx_fifo_empty = (rx_rd == rx_wr);
  assign bus.uart_rx_fifo_data  = rx_mem[rx_rd[3:0]];

  always @(posedge clk) begin
    if (bus.uart_tx_fifo_wr_en) begin
      tx_mem[tx_cnt[7:0]] <= bus.uart_tx_fifo_data;
      tx_cnt <= tx_cnt + 1;
    end
    if (bus.out_rx_fifo_wr_en) begin
      out_mem[out_cnt[7:0]] <= bus.out_rx_fifo_data;
      out_cnt <= out_cnt + 1;
    end
    if (bus.uart_rx_fifo_rd_en) rx_rd <= rx_rd + 1;
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
  endtask

  task automatic push_rx(input logic [7:0] b);
    rx_mem[rx_wr[3:0]] = b;
    rx_wr++;
  endtask

  task automatic pulse_tx();
    @(negedge clk); bus.tx_start = 1'b1;
    @(negedge clk); bus.tx_start = 1'b0;
  endtask

  task automatic pulse_rx();
    @(negedge clk); bus.rx_start = 1'b1;
    @(negedge clk); bus.rx_start = 1'b0;
  endtask

  task automatic wait_idle(input string tag, input int budget);
    logic done;
    done = 1'b0;
    for (int i = 0; i < budget && !done; i++) begin
      @(negedge clk);
      done = bus.tx_ready;
    end
    if (!done) check({tag, "_idle_timeout"}, 32'(done), 32'd1);
  endtask

  task automatic wait_tx_cnt(input string tag, input int target, input int budget);
    logic done;
    done = 1'b0;
    for (int i = 0; i < budget && !done; i++) begin
      @(negedge clk);
      done = (tx_cnt >= target);
    end
    if (!done) check({tag, "_txcnt_timeout"}, 32'(tx_cnt), 32'(target));
  endtask

  task automatic set_cmd(input updi_instruction ins, input logic [1:0] a, input logic [1:0] b,
                         input logic [1:0] p, input logic [1:0] c, input logic [3:0] cs,
                         input logic s, input logic [DATA_ADDR_BITS-1:0] len);
    bus.instruction    = ins;
    bus.size_a         = a;
    bus.size_b         = b;
    bus.ptr            = p;
    bus.size_c         = c;
    bus.cs_addr        = cs;
    bus.sib            = s;
    bus.data_len       = len;
    bus.data           = '0;
    bus.wait_ack_after = '0;
  endtask

  task automatic run_enc(input string tag, input updi_instruction ins, input logic [1:0] a,
                         input logic [1:0] b, input logic [1:0] p, input logic [1:0] c,
                         input logic [3:0] cs, input logic s, input logic [7:0] exp);
    int base;
    set_cmd(ins, a, b, p, c, cs, s, '0);
    base = tx_cnt;
    pulse_tx();
    wait_idle(tag, 10);
    check({tag, "_count"}, 32'(tx_cnt - base), 32'd2);
    check({tag, "_opcode"}, 32'(tx_mem[(base + 1) % 256]), 32'(exp));
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    int base;
    int obase;
    logic [7:0] exp_bytes [6];

    bus.tx_start          = 1'b0;
    bus.rx_start          = 1'b0;
    bus.rx_n_bytes        = '0;
    bus.uart_tx_fifo_full = 1'b0;
    bus.out_rx_fifo_full  = 1'b0;
    set_cmd(LDS, 2'd0, 2'd0, 2'd0, 2'd0, 4'd0, 1'b0, '0);

    // Reset state
    repeat (3) @(negedge clk);
    check("rst_tx_ready", 32'(bus.tx_ready), 32'd1);
    check("rst_rx_ready", 32'(bus.rx_ready), 32'd1);
    check("rst_strobes", 32'({bus.uart_tx_fifo_wr_en, bus.uart_rx_fifo_rd_en, bus.out_rx_fifo_wr_en}), 32'd0);
    check("rst_ack_error", 32'(bus.ack_error), 32'd0);
    rst_n = 1'b1;

    // ST ptr=2, two bytes, ACK after byte 1 with latency checks
    set_cmd(ST, 2'd0, 2'd0, 2'd2, 2'd0, 4'd0, 1'b0, 6'd2);
    bus.data[0] = 8'h12; bus.data[1] = 8'h34; bus.wait_ack_after[1] = 1'b1;
    base = tx_cnt;
    pulse_tx();
    check("lat_synch_wr", 32'(bus.uart_tx_fifo_wr_en), 32'd1);
    check("lat_synch_data", 32'(bus.uart_tx_fifo_data), 32'h55);
    @(negedge clk);
    check("lat_opcode_data", 32'(bus.uart_tx_fifo_data), 32'h68);
    @(negedge clk);
    check("lat_data0", 32'(bus.uart_tx_fifo_data), 32'h12);
    repeat (4) @(negedge clk);
    check("st_waiting", 32'(bus.tx_ready), 32'd0);
    check("st_tx_count", 32'(tx_cnt - base), 32'd4);
    check("st_byte3", 32'(tx_mem[(base + 3) % 256]), 32'h34);
    push_rx(8'h40);
    wait_idle("st_ack", 20);
    check("st_ack_error", 32'(bus.ack_error), 32'd0);
    check("st_ack_popped", 32'(rx_rd), 32'(rx_wr));

    // Same command, bad ACK
    base = tx_cnt;
    pulse_tx();
    repeat (6) @(negedge clk);
    push_rx(8'h41);
    wait_idle("bad_ack", 20);
    repeat (2) @(negedge clk);
    check("bad_ack_error", 32'(bus.ack_error), 32'(EXP_BAD_ACK));
    check("bad_ack_popped", 32'(rx_rd), 32'(rx_wr));
    check("bad_ack_tx_count", 32'(tx_cnt - base), 32'd4);

    // LDCS with no payload; tx_start clears ack_error
    set_cmd(LDCS, 2'd0, 2'd0, 2'd0, 2'd0, 4'h0, 1'b0, '0);
    base = tx_cnt;
    pulse_tx();
    check("ldcs_ack_cleared", 32'(bus.ack_error), 32'd0);
    check("ldcs_busy0", 32'(bus.tx_ready), 32'd0);
    @(negedge clk);
    check("ldcs_busy1", 32'(bus.tx_ready), 32'd0);
    @(negedge clk);
    check("ldcs_idle", 32'(bus.tx_ready), 32'd1);
    check("ldcs_synch", 32'(tx_mem[base % 256]), 32'h55);
    check("ldcs_opcode", 32'(tx_mem[(base + 1) % 256]), 32'h80);

    // Opcode encodings
    run_enc("enc_lds", LDS, 2'd2, 2'd1, 2'd0, 2'd0, 4'h0, 1'b0, 8'h09);
    run_enc("enc_ld", LD, 2'd0, 2'd1, 2'd1, 2'd0, 4'h0, 1'b0, 8'h25);
    run_enc("enc_stcs", STCS, 2'd0, 2'd0, 2'd0, 2'd0, 4'h3, 1'b0, 8'hC3);
    run_enc("enc_repeat", REPEAT, 2'd0, 2'd3, 2'd0, 2'd0, 4'h0, 1'b0, 8'hA3);
    run_enc("enc_key", KEY, 2'd0, 2'd0, 2'd0, 2'd2, 4'h0, 1'b1, 8'hE6);

    // ACK after the first of three bytes, then resume
    set_cmd(STS, 2'd1, 2'd0, 2'd0, 2'd0, 4'h0, 1'b0, 6'd3);
    bus.data[0] = 8'hA1; bus.data[1] = 8'hA2; bus.data[2] = 8'hA3;
    bus.wait_ack_after[0] = 1'b1;
    push_rx(8'h40);
    base = tx_cnt;
    pulse_tx();
    wait_idle("resume", 20);
    check("resume_count", 32'(tx_cnt - base), 32'd5);
    check("resume_opcode", 32'(tx_mem[(base + 1) % 256]), 32'h44);
    check("resume_b1", 32'(tx_mem[(base + 3) % 256]), 32'hA2);
    check("resume_b2", 32'(tx_mem[(base + 4) % 256]), 32'hA3);
    check("resume_popped", 32'(rx_rd), 32'(rx_wr));

    // Receive three bytes
    push_rx(8'hAA); push_rx(8'hBB); push_rx(8'hCC);
    bus.rx_n_bytes = 6'd3;
    obase = out_cnt;
    pulse_rx();
    wait_idle("rx3", 20);
    check("rx3_count", 32'(out_cnt - obase), 32'd3);
    check("rx3_b0", 32'(out_mem[obase % 256]), 32'hAA);
    check("rx3_b1", 32'(out_mem[(obase + 1) % 256]), 32'hBB);
    check("rx3_b2", 32'(out_mem[(obase + 2) % 256]), 32'hCC);

    // Receive zero bytes
    bus.rx_n_bytes = '0;
    obase = out_cnt;
    pulse_rx();
    check("rx0_busy", 32'(bus.rx_ready), 32'd0);
    @(negedge clk);
    check("rx0_idle", 32'(bus.rx_ready), 32'd1);
    check("rx0_count", 32'(out_cnt - obase), 32'd0);

    // tx_start wins over rx_start
    set_cmd(LDCS, 2'd0, 2'd0, 2'd0, 2'd0, 4'h1, 1'b0, '0);
    bus.rx_n_bytes = 6'd1;
    base = tx_cnt;
    obase = out_cnt;
    @(negedge clk); bus.tx_start = 1'b1; bus.rx_start = 1'b1;
    @(negedge clk); bus.tx_start = 1'b0; bus.rx_start = 1'b0;
    wait_idle("prio", 10);
    check("prio_tx_count", 32'(tx_cnt - base), 32'd2);
    check("prio_opcode", 32'(tx_mem[(base + 1) % 256]), 32'h81);

    // TX FIFO full for five cycles mid-payload
    set_cmd(STS, 2'd0, 2'd0, 2'd0, 2'd0, 4'h0, 1'b0, 6'd4);
    bus.data[0] = 8'h01; bus.data[1] = 8'h02; bus.data[2] = 8'h03; bus.data[3] = 8'h04;
    exp_bytes = '{8'h55, 8'h40, 8'h01, 8'h02, 8'h03, 8'h04};
    base = tx_cnt;
    pulse_tx();
    wait_tx_cnt("stall", base + 3, 10);
    bus.uart_tx_fifo_full = 1'b1;
    repeat (5) @(negedge clk);
    check("stall_no_write", 32'(tx_cnt - base), 32'd3);
    check("stall_busy", 32'(bus.tx_ready), 32'd0);
    bus.uart_tx_fifo_full = 1'b0;
    wait_idle("stall", 20);
    check("stall_count", 32'(tx_cnt - base), 32'd6);
    for (int i = 0; i < 6; i++)
      check($sformatf("stall_b%0d", i), 32'(tx_mem[(base + i) % 256]), 32'(exp_bytes[i]));

    // Reset during TX_DATA
    base = tx_cnt;
    pulse_tx();
    wait_tx_cnt("rst_mid", base + 3, 10);
    rst_n = 1'b0;
    #1;
    check("rstmid_tx_ready", 32'(bus.tx_ready), 32'd1);
    check("rstmid_strobes", 32'({bus.uart_tx_fifo_wr_en, bus.uart_rx_fifo_rd_en, bus.out_rx_fifo_wr_en}), 32'd0);
    check("rstmid_ack_error", 32'(bus.ack_error), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    repeat (3) @(negedge clk);
    check("rstmid_no_more_tx", 32'(tx_cnt - base), 32'd3);
    check("rstmid_still_idle", 32'(bus.tx_ready), 32'd1);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
